// File: rtl/midi_voice_allocator_pkg.sv
// Shared definitions for the MIDI voice allocator: note width, FSM encoding
// and a constant clog2 helper used to size voice indices.
package midi_voice_allocator_pkg;

    localparam int NOTE_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } alloc_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/midi_voice_slot.sv
// One voice: holds its frequency index, gate and saturating age counter.
module midi_voice_slot
    import midi_voice_allocator_pkg::*;
#(
    parameter int AGE_W = 4
) (
    input  logic              inCLK_50MHZ,
    input  logic              inRESET,
    input  logic              inLoad,
    input  logic [NOTE_W-1:0] inLoadNote,
    input  logic              inRelease,
    input  logic              inAgeTick,
    input  logic              inClearAll,
    output logic [NOTE_W-1:0] outNote,
    output logic              outGate,
    output logic [AGE_W-1:0]  outAge
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // NOTE: every state register uses <= so all slots update from the same pre-edge values.
    always_ff @(posedge inCLK_50MHZ) begin
        if (inRESET) begin
            outNote <= '0;
            outGate <= 1'b0;
            outAge  <= '0;
        end else if (inClearAll) begin
            outGate <= 1'b0;
        end else if (inLoad) begin
            outNote <= inLoadNote;
            outGate <= 1'b1;
            outAge  <= '0;
        end else if (inRelease) begin
            outGate <= 1'b0;
        end else if (inAgeTick && outGate && outAge != AGE_MAX) begin
            outAge <= outAge + 1'b1;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice scheduler: scans voices one per cycle, then retriggers,
// allocates a free voice, steals the oldest, or releases on note-off.
module midi_voice_allocator
    import midi_voice_allocator_pkg::*;
#(
    parameter  int VOICES = 4,
    parameter  int AGE_W  = 4,
    localparam int IDX_W  = clog2(VOICES)
) (
    input  logic                     inCLK_50MHZ,
    input  logic                     inRESET,
    input  logic                     inNoteValid,
    input  logic                     inNoteOn,
    input  logic [NOTE_W-1:0]        inNoteNumber,
    output logic                     outNoteReady,
    input  logic                     inAllNotesOff,
    output logic [VOICES*NOTE_W-1:0] outVoiceNotes,
    output logic [VOICES-1:0]        outVoiceGates,
    output logic                     outVoiceUpdate,
    output logic [IDX_W-1:0]         outVoiceIndex,
    output logic                     outVoiceStolen
);

    alloc_state_t      state;
    logic              ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [IDX_W-1:0]  scan_idx;
    logic              match_found, free_found, oldest_found;
    logic [IDX_W-1:0]  match_idx, free_idx, oldest_idx;
    logic [AGE_W-1:0]  oldest_age;

    logic [NOTE_W-1:0] slot_note [VOICES];
    logic [AGE_W-1:0]  slot_age  [VOICES];

    logic              cur_gate;
    logic [NOTE_W-1:0] cur_note;
    logic [AGE_W-1:0]  cur_age;
    logic [IDX_W-1:0]  target_idx;
    logic              target_stolen;
    logic              commit_on, commit_off, panic;

    // Panic blocks acceptance combinationally so a held panic never races an event.
    assign outNoteReady = (state == IDLE) && !inAllNotesOff;
    assign panic        = (state == IDLE) && inAllNotesOff;

    assign cur_gate = outVoiceGates[scan_idx];
    assign cur_note = slot_note[scan_idx];
    assign cur_age  = slot_age[scan_idx];

    // NOTE: defaults first so no path through this block leaves a value unassigned (no latch).
    always_comb begin
        target_idx    = oldest_idx;
        target_stolen = 1'b1;
        if (match_found) begin
            target_idx    = match_idx;
            target_stolen = 1'b0;
        end else if (free_found) begin
            target_idx    = free_idx;
            target_stolen = 1'b0;
        end
        commit_on  = (state == COMMIT) && ev_on;
        commit_off = (state == COMMIT) && !ev_on && match_found;
    end

    for (genvar i = 0; i < VOICES; i++) begin : g_slot
        midi_voice_slot #(.AGE_W(AGE_W)) u_slot (
            .inCLK_50MHZ (inCLK_50MHZ),
            .inRESET     (inRESET),
            .inLoad      (commit_on && target_idx == IDX_W'(i)),
            .inLoadNote  (ev_note),
            .inRelease   (commit_off && match_idx == IDX_W'(i)),
            .inAgeTick   (commit_on && target_idx != IDX_W'(i)),
            .inClearAll  (panic),
            .outNote     (slot_note[i]),
            .outGate     (outVoiceGates[i]),
            .outAge      (slot_age[i])
        );
        assign outVoiceNotes[NOTE_W*i +: NOTE_W] = slot_note[i];
    end

    always_ff @(posedge inCLK_50MHZ) begin
        if (inRESET) begin
            state          <= IDLE;
            ev_on          <= 1'b0;
            ev_note        <= '0;
            scan_idx       <= '0;
            match_found    <= 1'b0;
            free_found     <= 1'b0;
            oldest_found   <= 1'b0;
            match_idx      <= '0;
            free_idx       <= '0;
            oldest_idx     <= '0;
            oldest_age     <= '0;
            outVoiceUpdate <= 1'b0;
            outVoiceIndex  <= '0;
            outVoiceStolen <= 1'b0;
        end else begin
            outVoiceUpdate <= 1'b0;
            case (state)
                IDLE: begin
                    if (inNoteValid && outNoteReady) begin
                        ev_on        <= inNoteOn;
                        ev_note      <= inNoteNumber;
                        scan_idx     <= '0;
                        match_found  <= 1'b0;
                        free_found   <= 1'b0;
                        oldest_found <= 1'b0;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_gate && cur_note == ev_note && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!cur_gate && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (cur_gate && (!oldest_found || cur_age > oldest_age)) begin
                        oldest_found <= 1'b1;
                        oldest_idx   <= scan_idx;
                        oldest_age   <= cur_age;
                    end
                    if (scan_idx == IDX_W'(VOICES - 1)) state <= COMMIT;
                    else scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    if (ev_on || match_found) begin
                        outVoiceUpdate <= 1'b1;
                        outVoiceIndex  <= target_idx;
                        outVoiceStolen <= ev_on && target_stolen;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench: a behavioural voice model predicts each commit; a monitor
// compares every update pulse against the queued prediction.
module tb_midi_voice_allocator;

    localparam int VOICES  = 4;
    localparam int AGE_W   = 4;
    localparam int IDX_W   = 2;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    valid = 1'b0;
    logic                    on = 1'b0;
    logic [6:0]              note = '0;
    logic                    all_off = 1'b0;
    logic                    ready;
    logic [VOICES*7-1:0]     notes;
    logic [VOICES-1:0]       gates;
    logic                    upd;
    logic [IDX_W-1:0]        upd_idx;
    logic                    stolen;

    always #10 clk = ~clk;

    midi_voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
        .inCLK_50MHZ    (clk),
        .inRESET        (rst),
        .inNoteValid    (valid),
        .inNoteOn       (on),
        .inNoteNumber   (note),
        .outNoteReady   (ready),
        .inAllNotesOff  (all_off),
        .outVoiceNotes  (notes),
        .outVoiceGates  (gates),
        .outVoiceUpdate (upd),
        .outVoiceIndex  (upd_idx),
        .outVoiceStolen (stolen)
    );

    typedef struct {
        int                  idx;
        bit                  stolen;
        logic [VOICES*7-1:0] notes;
        logic [VOICES-1:0]   gates;
    } exp_t;

    exp_t exp_q[$];
    int   m_note [VOICES];
    int   m_gate [VOICES];
    int   m_age  [VOICES];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [VOICES*7-1:0] model_notes();
        logic [VOICES*7-1:0] v;
        for (int i = 0; i < VOICES; i++) v[7*i +: 7] = 7'(m_note[i]);
        return v;
    endfunction

    function automatic logic [VOICES-1:0] model_gates();
        logic [VOICES-1:0] v;
        for (int i = 0; i < VOICES; i++) v[i] = (m_gate[i] != 0);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < VOICES; i++) begin
            m_note[i] = 0;
            m_gate[i] = 0;
            m_age[i]  = 0;
        end
        exp_q.delete();
    endtask

    // Voice policy: retrigger a sounding copy, else lowest free voice, else oldest.
    task automatic model_event(input bit ev_on, input int n);
        int   match, free, oldest, target;
        exp_t e;
        match = -1; free = -1; oldest = -1;
        for (int i = 0; i < VOICES; i++) begin
            if (m_gate[i] != 0 && m_note[i] == n && match < 0) match = i;
            if (m_gate[i] == 0 && free < 0) free = i;
            if (m_gate[i] != 0 && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
        end
        if (ev_on) begin
            target   = (match >= 0) ? match : (free >= 0) ? free : oldest;
            e.stolen = (match < 0 && free < 0);
            for (int i = 0; i < VOICES; i++)
                if (i != target && m_gate[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
            m_note[target] = n;
            m_gate[target] = 1;
            m_age[target]  = 0;
            e.idx   = target;
            e.notes = model_notes();
            e.gates = model_gates();
            exp_q.push_back(e);
        end else if (match >= 0) begin
            m_gate[match] = 0;
            e.idx    = match;
            e.stolen = 1'b0;
            e.notes  = model_notes();
            e.gates  = model_gates();
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (upd) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_update: index %0d stolen %0d, expected no pulse at %0t",
                         upd_idx, stolen, $time);
            end else begin
                e = exp_q.pop_front();
                check("update_index", 32'(upd_idx), 32'(e.idx));
                check("update_stolen", 32'(stolen), 32'(e.stolen));
                check("update_notes", 32'(notes), 32'(e.notes));
                check("update_gates", 32'(gates), 32'(e.gates));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; all_off = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic accept(input bit ev_on, input int n);
        int waited;
        waited = 0;
        @(negedge clk);
        valid = 1'b1; on = ev_on; note = 7'(n);
        while (!ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            check("accept_timeout", 32'(ready), 32'd1);
            valid = 1'b0;
        end else begin
            @(posedge clk);
            model_event(ev_on, n);
            #1 valid = 1'b0;
        end
    endtask

    // Ready stays low from the accept edge until the cycle after COMMIT.
    task automatic settle();
        int gap;
        gap = 0;
        @(negedge clk);
        while (!ready && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        check("ready_gap", 32'(gap), 32'(VOICES + 1));
        @(posedge clk);
        #1;
        check("pending_updates", 32'(exp_q.size()), 32'd0);
        check("voice_notes", 32'(notes), 32'(model_notes()));
        check("voice_gates", 32'(gates), 32'(model_gates()));
        exp_q.delete();
    endtask

    task automatic send(input bit ev_on, input int n);
        accept(ev_on, n);
        settle();
    endtask

    task automatic panic_pulse(input bit with_event);
        @(negedge clk);
        all_off = 1'b1; valid = with_event; on = 1'b1; note = 7'd55;
        #1 check("panic_ready", 32'(ready), 32'd0);
        @(posedge clk);
        for (int i = 0; i < VOICES; i++) m_gate[i] = 0;
        @(negedge clk);
        check("panic_gates", 32'(gates), 32'd0);
        check("panic_notes", 32'(notes), 32'(model_notes()));
        all_off = 1'b0; valid = 1'b0;
        repeat (VOICES + 3) @(negedge clk);
        check("panic_no_update", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_notes", 32'(notes), 32'd0);
        check("reset_gates", 32'(gates), 32'd0);
        check("reset_update", 32'(upd), 32'd0);
        check("reset_index", 32'(upd_idx), 32'd0);
        check("reset_stolen", 32'(stolen), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);

        // Fill all voices, then steal the oldest.
        send(1'b1, 60);
        check("first_note", 32'(notes[6:0]), 32'd60);
        send(1'b1, 64);
        send(1'b1, 67);
        send(1'b1, 72);
        check("four_gates", 32'(gates), 32'hF);
        send(1'b1, 76);

        // Release, then a release of a note no longer sounding.
        send(1'b0, 64);
        send(1'b0, 64);

        // Retrigger of an already sounding note.
        do_reset();
        send(1'b1, 60);
        send(1'b1, 60);
        check("retrigger_gates", 32'(gates), 32'h1);

        // Panic held together with an event in IDLE.
        send(1'b1, 62);
        panic_pulse(1'b1);
        send(1'b1, 50);

        // Reset in the middle of a scan drops the event.
        send(1'b1, 70);
        accept(1'b1, 61);
        repeat (2) @(posedge clk);
        do_reset();
        @(negedge clk);
        check("midreset_notes", 32'(notes), 32'd0);
        check("midreset_gates", 32'(gates), 32'd0);
        check("midreset_ready", 32'(ready), 32'd1);
        repeat (VOICES + 4) @(negedge clk);
        check("midreset_no_update", 32'(upd), 32'd0);

        // Voice 0 held while voices 2 and 3 are retriggered: ages of voices 0
        // and 1 both pin at the maximum, so the tie picks voice 0.
        send(1'b1, 10);
        send(1'b1, 11);
        send(1'b1, 12);
        send(1'b1, 13);
        for (int k = 0; k < 13; k++) send(1'b1, (k % 2 == 0) ? 12 : 13);
        send(1'b1, 20);
        for (int k = 0; k < 4; k++) send(1'b1, 21 + k);

        // Random traffic over a small note pool to force retriggers and steals.
        do_reset();
        for (int k = 0; k < 150; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) panic_pulse(r[0]);
            else send(r < 68, 40 + int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
